// File: rtl/prim_arbiter_wrr.sv
// Weighted round-robin N:1 arbiter with packet lock and zero-latency data path.
// Ports: req/data/last/weight in per port; gnt/idx/valid/data/last/locked out; ready_i from sink.
module prim_arbiter_wrr #(
  parameter int unsigned N          = 8,
  parameter int unsigned DW         = 32,
  parameter int unsigned WW         = 4,
  parameter bit          EnDataPort = 1'b1,
  parameter bit          EnLock     = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N-1:0]               req_i,
  input  logic [N-1:0][DW-1:0]       data_i,
  input  logic [N-1:0]               last_i,
  input  logic [N-1:0][WW-1:0]       weight_i,
  output logic [N-1:0]               gnt_o,
  output logic [$clog2(N)-1:0]       idx_o,
  output logic                       valid_o,
  output logic [DW-1:0]              data_o,
  output logic                       last_o,
  input  logic                       ready_i,
  output logic                       locked_o
);

  localparam int unsigned IdxW = $clog2(N);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [WW-1:0]   rem_q, rem_d;
  logic [WW-1:0]   wgt_q, wgt_d;
  logic            lock_q, lock_d;
  logic            hold_q, hold_d;

  logic            held;
  logic            cont;
  logic            srch_hit;
  logic [IdxW-1:0] srch_idx;
  logic [IdxW-1:0] sel;
  logic            sel_vld;
  logic            acc;
  logic            new_turn;
  logic            pkt_end;
  logic [WW-1:0]   eff;

  assign held = lock_q | hold_q;
  assign cont = !held && (rem_q != '0) && req_i[ptr_q];

  // Cyclic search starting after the last winner; the winner itself is last.
  always_comb begin
    logic [IdxW-1:0] cand;
    srch_hit = 1'b0;
    srch_idx = ptr_q;
    cand     = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % N);
      if (!srch_hit && req_i[cand]) begin
        srch_hit = 1'b1;
        srch_idx = cand;
      end
    end
  end

  always_comb begin
    sel     = ptr_q;
    sel_vld = 1'b0;
    if (held) begin
      sel_vld = req_i[ptr_q];
    end else if (cont) begin
      sel_vld = 1'b1;
    end else begin
      sel     = srch_idx;
      sel_vld = srch_hit;
    end
  end

  // A held choice is a turn start exactly when rem_q was cleared at hold
  // time; a locked packet always has rem_q >= 1.
  assign new_turn = held ? (rem_q == '0) : !cont;
  assign acc      = sel_vld & ready_i;
  assign pkt_end  = EnLock ? last_i[sel] : 1'b1;
  assign eff      = (weight_i[sel] == '0) ? WW'(1) : weight_i[sel];

  always_comb begin
    ptr_d  = ptr_q;
    rem_d  = rem_q;
    wgt_d  = wgt_q;
    lock_d = lock_q;
    hold_d = hold_q;
    if (acc) begin
      ptr_d  = sel;
      hold_d = 1'b0;
      lock_d = !pkt_end;
      if (new_turn) begin
        wgt_d = eff;
        rem_d = eff - WW'(pkt_end);
      end else begin
        rem_d = rem_q - WW'(pkt_end);
      end
    end else if (sel_vld) begin
      hold_d = 1'b1;
      ptr_d  = sel;
      if (new_turn) rem_d = '0;
    end else if (!held && rem_q != '0 && !req_i[ptr_q]) begin
      rem_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q  <= IdxW'(N - 1);
      rem_q  <= '0;
      wgt_q  <= '0;
      lock_q <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      rem_q  <= rem_d;
      wgt_q  <= wgt_d;
      lock_q <= lock_d;
      hold_q <= hold_d;
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      gnt_o[i] = !rst_i && acc && (sel == IdxW'(i));
    end
  end

  assign idx_o    = rst_i ? '0 : sel;
  assign valid_o  = !rst_i && sel_vld;
  assign last_o   = !rst_i && last_i[sel];
  assign locked_o = !rst_i && lock_q;
  assign data_o   = !EnDataPort ? '1 :
                    (rst_i ? '0 : data_i[sel]);

  a_gnt_oh: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(gnt_o));
  a_gnt_hs: assert property (@(posedge clk_i) disable iff (rst_i)
    (|gnt_o) |-> (valid_o && ready_i));
  a_hs_gnt: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && ready_i) |-> gnt_o[idx_o]);
  a_data: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && EnDataPort) |-> (data_o == data_i[idx_o]));
  a_held: assert property (@(posedge clk_i) disable iff (rst_i)
    held |-> (idx_o == ptr_q && req_i[ptr_q]));
  a_rem: assert property (@(posedge clk_i) disable iff (rst_i)
    rem_q <= wgt_q);

endmodule

// File: tb/tb_prim_arbiter_wrr.sv
// Directed testbench for prim_arbiter_wrr.
// Hand-computed grant sequences for weights, lock, backpressure and reset.
module tb_prim_arbiter_wrr;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int WW = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [N-1:0]         req_i;
  logic [N-1:0][DW-1:0] data_i;
  logic [N-1:0]         last_i;
  logic [N-1:0][WW-1:0] weight_i;
  logic [N-1:0]         gnt_o;
  logic [2:0]           idx_o;
  logic                 valid_o;
  logic [DW-1:0]        data_o;
  logic                 last_o;
  logic                 ready_i;
  logic                 locked_o;

  int n_chk = 0;
  int n_err = 0;

  prim_arbiter_wrr #(
    .N(N), .DW(DW), .WW(WW),
    .EnDataPort(1'b1), .EnLock(1'b1)
  ) u_dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .data_i   (data_i),
    .last_i   (last_i),
    .weight_i (weight_i),
    .gnt_o    (gnt_o),
    .idx_o    (idx_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .last_o   (last_o),
    .ready_i  (ready_i),
    .locked_o (locked_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic smp;
    @(negedge clk_i);
  endtask

  task automatic nxt;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_w1;
    for (int i = 0; i < N; i++) weight_i[i] = 4'd1;
  endtask

  task automatic do_rst;
    rst_i   = 1'b1;
    req_i   = '0;
    last_i  = '1;
    ready_i = 1'b1;
    nxt();
    rst_i   = 1'b0;
  endtask

  // One accepted beat: checks index, grant vector and data.
  task automatic beat(input string tag, input int e);
    smp();
    chk({tag, "_idx"}, 32'(idx_o), 32'(e));
    chk({tag, "_gnt"}, 32'(gnt_o), 32'd1 << e);
    chk({tag, "_dat"}, data_o, 32'hA5A5_0000 | 32'(e));
    nxt();
  endtask

  int exp1[8] = '{0, 0, 1, 2, 0, 0, 1, 2};
  int exp4[4] = '{0, 1, 0, 1};
  int exp5[5] = '{0, 0, 1, 0, 1};

  initial begin
    for (int i = 0; i < N; i++) data_i[i] = 32'hA5A5_0000 | 32'(i);
    set_w1();
    rst_i   = 1'b1;
    req_i   = '1;
    last_i  = '1;
    ready_i = 1'b1;
    nxt();

    // Outputs forced low while reset is held
    smp();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_idx", 32'(idx_o), 32'd0);
    chk("rst_lock", 32'(locked_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    nxt();
    rst_i = 1'b0;
    req_i = '0;
    smp();
    chk("idle_valid", 32'(valid_o), 32'd0);
    chk("idle_gnt", 32'(gnt_o), 32'd0);
    nxt();

    // Weights {2,1,1}
    do_rst();
    weight_i[0] = 4'd2;
    req_i = 8'b0000_0111;
    for (int k = 0; k < 8; k++) beat("wrr", exp1[k]);

    // 3-beat locked packet on port 1
    do_rst();
    set_w1();
    last_i = '0;
    req_i  = 8'b0000_0010;
    smp();
    chk("lk0_idx", 32'(idx_o), 32'd1);
    chk("lk0_lock", 32'(locked_o), 32'd0);
    nxt();
    req_i = 8'b0000_0011;
    smp();
    chk("lk1_idx", 32'(idx_o), 32'd1);
    chk("lk1_gnt", 32'(gnt_o), 32'h2);
    chk("lk1_lock", 32'(locked_o), 32'd1);
    nxt();
    last_i[1] = 1'b1;
    smp();
    chk("lk2_idx", 32'(idx_o), 32'd1);
    chk("lk2_lock", 32'(locked_o), 32'd1);
    chk("lk2_last", 32'(last_o), 32'd1);
    nxt();
    last_i = '1;
    smp();
    chk("lk3_idx", 32'(idx_o), 32'd0);
    chk("lk3_gnt", 32'(gnt_o), 32'h1);
    chk("lk3_lock", 32'(locked_o), 32'd0);
    nxt();

    // Backpressure hold on port 2
    do_rst();
    req_i   = 8'b0000_0100;
    ready_i = 1'b0;
    smp();
    chk("bp0_idx", 32'(idx_o), 32'd2);
    chk("bp0_gnt", 32'(gnt_o), 32'd0);
    chk("bp0_vld", 32'(valid_o), 32'd1);
    nxt();
    req_i = 8'b0000_1100;
    for (int k = 1; k < 4; k++) begin
      smp();
      chk("bp_idx", 32'(idx_o), 32'd2);
      chk("bp_gnt", 32'(gnt_o), 32'd0);
      nxt();
    end
    ready_i = 1'b1;
    smp();
    chk("bp_rel_gnt", 32'(gnt_o), 32'h4);
    nxt();
    smp();
    chk("bp_next_idx", 32'(idx_o), 32'd3);
    nxt();

    // Weight 0 behaves as weight 1
    do_rst();
    set_w1();
    weight_i[0] = 4'd0;
    req_i = 8'b0000_0011;
    for (int k = 0; k < 4; k++) beat("w0", exp4[k]);

    // Weight change mid-turn only applies at next turn
    do_rst();
    set_w1();
    weight_i[0] = 4'd3;
    req_i = 8'b0000_0011;
    beat("wc0", 0);
    weight_i[0] = 4'd1;
    for (int k = 0; k < 5; k++) beat("wc", exp5[k]);

    // Reset in the middle of a locked packet
    do_rst();
    set_w1();
    req_i  = 8'b0000_0100;
    last_i = '0;
    beat("mr0", 2);
    smp();
    chk("mr_lock", 32'(locked_o), 32'd1);
    nxt();
    rst_i = 1'b1;
    smp();
    chk("mr_rst_lock", 32'(locked_o), 32'd0);
    chk("mr_rst_vld", 32'(valid_o), 32'd0);
    nxt();
    rst_i  = 1'b0;
    req_i  = 8'b0010_0010;
    last_i = '1;
    smp();
    chk("mr_idx", 32'(idx_o), 32'd1);
    chk("mr_gnt", 32'(gnt_o), 32'h2);
    chk("mr_lock2", 32'(locked_o), 32'd0);
    nxt();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
